// File: rtl/nasti_stream_pkg.sv
// Shared definitions for the NASTI-stream arbiters.
//   arb_state_t : two-state arbitration FSM encoding (IDLE / BUSY)
//   rr_pick()   : round-robin winner search, reused by every stream arbiter.
//                 Supports up to RR_MAX_PORTS requesters.
package nasti_stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int unsigned RR_MAX_PORTS = 32;
  localparam int unsigned RR_IDX_W     = 5;

  // Returns the first requesting index found when scanning upward from
  // (last + 1) mod n_port with wrap-around. With no request the previous
  // index is returned unchanged; callers only use the result when |req.
  function automatic logic [RR_IDX_W-1:0] rr_pick(
    input logic [RR_MAX_PORTS-1:0] req,
    input logic [RR_IDX_W-1:0]     last,
    input int unsigned             n_port
  );
    logic [RR_IDX_W-1:0] pick;
    logic                found;
    int unsigned         idx;
    pick  = last;
    found = 1'b0;
    for (int unsigned k = 1; k <= RR_MAX_PORTS; k++) begin
      idx = (32'(last) + k) % n_port;
      if (!found && (k <= n_port) && req[idx]) begin
        pick  = idx[RR_IDX_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/nasti_stream_skid.sv
// Generic two-register valid/ready buffer.
//   aclk, aresetn      : clock, asynchronous active-low reset
//   in_valid/in_ready  : upstream handshake, in_data payload
//   out_valid/out_ready: downstream handshake, out_data payload (from out_reg)
// in_ready depends only on skid_valid, and out_valid/out_data come straight
// from registers, so no combinational path crosses the buffer. A full
// out_reg that is not draining diverts one extra beat into skid_reg; the
// upstream is throttled only once skid_reg holds that beat.
module nasti_stream_skid
  import nasti_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] skid_reg;
  logic             skid_valid;
  logic             in_fire;
  logic             out_free;

  assign in_ready = ~skid_valid;
  assign in_fire  = in_valid & ~skid_valid;
  // out_reg can take a new beat when empty or when it is being drained now.
  assign out_free = ~out_valid | out_ready;
  assign out_data = out_reg;

  // Output/skid register update: skid_reg always refills out_reg first so
  // beat order is preserved.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_reg    <= '0;
      skid_reg   <= '0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_reg    <= skid_reg;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (in_fire) begin
        out_reg    <= in_data;
        out_valid  <= 1'b1;
      end else begin
        out_valid  <= 1'b0;
      end
    end else if (in_fire) begin
      skid_reg   <= in_data;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/nasti_stream_rr_arbiter.sv
// Packet-atomic round-robin N:1 arbiter for NASTI-stream.
//   aclk, aresetn        : clock, asynchronous active-low reset
//   master_t_*           : N_PORT input streams, flattened (port i occupies
//                          slice i of every bus); master_t_ready is returned
//   slave_t_*            : single arbitrated output stream, fully registered
// A grant is held on one source from its first beat until its t_last beat
// is accepted; the IDLE arbitration cycle between packets costs one bubble.
// N_PORT must lie in 1..RR_MAX_PORTS.
module nasti_stream_rr_arbiter
  import nasti_stream_pkg::*;
#(
  parameter int unsigned N_PORT     = 8,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned DEST_WIDTH = 1,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic [N_PORT-1:0]                   master_t_valid,
  output logic [N_PORT-1:0]                   master_t_ready,
  input  logic [N_PORT*DATA_WIDTH-1:0]        master_t_data,
  input  logic [N_PORT*(DATA_WIDTH/8)-1:0]    master_t_strb,
  input  logic [N_PORT*(DATA_WIDTH/8)-1:0]    master_t_keep,
  input  logic [N_PORT-1:0]                   master_t_last,
  input  logic [N_PORT*ID_WIDTH-1:0]          master_t_id,
  input  logic [N_PORT*DEST_WIDTH-1:0]        master_t_dest,
  input  logic [N_PORT*USER_WIDTH-1:0]        master_t_user,
  output logic                                slave_t_valid,
  input  logic                                slave_t_ready,
  output logic [DATA_WIDTH-1:0]               slave_t_data,
  output logic [DATA_WIDTH/8-1:0]             slave_t_strb,
  output logic [DATA_WIDTH/8-1:0]             slave_t_keep,
  output logic                                slave_t_last,
  output logic [ID_WIDTH-1:0]                 slave_t_id,
  output logic [DEST_WIDTH-1:0]               slave_t_dest,
  output logic [USER_WIDTH-1:0]               slave_t_user
);

  localparam int unsigned GW     = (N_PORT > 1) ? $clog2(N_PORT) : 1;
  localparam int unsigned SW     = DATA_WIDTH / 8;
  localparam int unsigned PAY_W  = DATA_WIDTH + 2 * SW + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

  arb_state_t        state;
  logic [GW-1:0]     grant;
  logic [GW-1:0]     last_grant;
  logic [GW-1:0]     winner;

  logic              sel_valid;
  logic              sel_last;
  logic [PAY_W-1:0]  sel_payload;
  logic              skid_in_ready;
  logic              accept;
  logic [PAY_W-1:0]  out_payload;

  assign winner = GW'(rr_pick(RR_MAX_PORTS'(master_t_valid), RR_IDX_W'(last_grant), N_PORT));

  // Only the granted port is offered to the skid stage, and only in BUSY.
  assign sel_valid = (state == BUSY) & master_t_valid[grant];
  assign sel_last  = master_t_last[grant];
  assign accept    = sel_valid & skid_in_ready;

  // All seven payload fields of the granted port travel as one word.
  assign sel_payload = {
    master_t_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH],
    master_t_strb[int'(grant)*SW +: SW],
    master_t_keep[int'(grant)*SW +: SW],
    sel_last,
    master_t_id[int'(grant)*ID_WIDTH +: ID_WIDTH],
    master_t_dest[int'(grant)*DEST_WIDTH +: DEST_WIDTH],
    master_t_user[int'(grant)*USER_WIDTH +: USER_WIDTH]
  };

  // Ready fan-out: only the granted port sees ready, gated by skid space.
  always_comb begin
    master_t_ready = '0;
    if (state == BUSY) begin
      master_t_ready[grant] = skid_in_ready;
    end else begin
      master_t_ready = '0;
    end
  end

  // Arbitration FSM. Leaving BUSY does not wait for the skid stage to
  // empty; buffered beats keep draining while the next packet is arbitrated.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(N_PORT - 1);
    end else begin
      case (state)
        IDLE: begin
          if (|master_t_valid) begin
            grant <= winner;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (accept && sel_last) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  nasti_stream_skid #(
    .WIDTH (PAY_W)
  ) u_skid (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_valid  (sel_valid),
    .in_ready  (skid_in_ready),
    .in_data   (sel_payload),
    .out_valid (slave_t_valid),
    .out_ready (slave_t_ready),
    .out_data  (out_payload)
  );

  assign {slave_t_data, slave_t_strb, slave_t_keep, slave_t_last,
          slave_t_id, slave_t_dest, slave_t_user} = out_payload;

endmodule

// File: tb/tb_nasti_stream_rr_arbiter.sv
// Scoreboard bench for nasti_stream_rr_arbiter: an 8-port instance and a
// 1-port instance. Tests push hand-computed expected beats into queues; a
// monitor pops and compares on every output handshake.
module tb_nasti_stream_rr_arbiter;

  localparam int NP = 8;
  localparam int DW = 64;
  localparam int SW = 8;
  localparam int PW = DW + 2 * SW + 4;

  typedef int offs_t [8];

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  // 8-port source models
  logic          drv_valid [NP];
  logic [DW-1:0] drv_data  [NP];
  logic          drv_last  [NP];

  logic [NP-1:0]    m_valid, m_ready, m_last, m_id, m_dest, m_user;
  logic [NP*DW-1:0] m_data;
  logic [NP*SW-1:0] m_strb, m_keep;

  logic          s_valid, s_last, s_id, s_dest, s_user;
  logic          s_ready = 1'b1;
  logic [DW-1:0] s_data;
  logic [SW-1:0] s_strb, s_keep;
  logic [PW-1:0] s_pay;

  // 1-port instance
  logic          d1_valid = 1'b0, d1_last = 1'b0, d1_ready;
  logic [DW-1:0] d1_data = '0;
  logic          s1_valid, s1_last, s1_id, s1_dest, s1_user;
  logic          s1_ready = 1'b1;
  logic [DW-1:0] s1_data;
  logic [SW-1:0] s1_strb, s1_keep;
  logic [PW-1:0] s1_pay;

  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] exp1_q[$];
  int            out_cyc[$];
  int            out_cyc1[$];

  int   acc_cnt   [NP];
  int   first_acc [NP];
  int   last_acc  [NP];
  logic abort   = 1'b0;
  logic chk_occ = 1'b0;
  int   occ     = 0;
  int   p6_in   = 0;

  // Sideband fields are derived from the data so every beat is unique.
  function automatic logic [PW-1:0] pay(input logic [DW-1:0] d, input logic l);
    return {d, d[7:0], ~d[7:0], l, d[0], d[1], d[2]};
  endfunction

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      m_valid[p]           = drv_valid[p];
      m_data[p*DW +: DW]   = drv_data[p];
      m_strb[p*SW +: SW]   = drv_data[p][7:0];
      m_keep[p*SW +: SW]   = ~drv_data[p][7:0];
      m_last[p]            = drv_last[p];
      m_id[p]              = drv_data[p][0];
      m_dest[p]            = drv_data[p][1];
      m_user[p]            = drv_data[p][2];
    end
  end

  assign s_pay  = {s_data, s_strb, s_keep, s_last, s_id, s_dest, s_user};
  assign s1_pay = {s1_data, s1_strb, s1_keep, s1_last, s1_id, s1_dest, s1_user};

  nasti_stream_rr_arbiter #(
    .N_PORT(NP), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1), .DATA_WIDTH(DW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .master_t_valid(m_valid), .master_t_ready(m_ready), .master_t_data(m_data),
    .master_t_strb(m_strb), .master_t_keep(m_keep), .master_t_last(m_last),
    .master_t_id(m_id), .master_t_dest(m_dest), .master_t_user(m_user),
    .slave_t_valid(s_valid), .slave_t_ready(s_ready), .slave_t_data(s_data),
    .slave_t_strb(s_strb), .slave_t_keep(s_keep), .slave_t_last(s_last),
    .slave_t_id(s_id), .slave_t_dest(s_dest), .slave_t_user(s_user)
  );

  nasti_stream_rr_arbiter #(
    .N_PORT(1), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1), .DATA_WIDTH(DW)
  ) dut1 (
    .aclk(aclk), .aresetn(aresetn),
    .master_t_valid(d1_valid), .master_t_ready(d1_ready), .master_t_data(d1_data),
    .master_t_strb(d1_data[7:0]), .master_t_keep(~d1_data[7:0]), .master_t_last(d1_last),
    .master_t_id(d1_data[0]), .master_t_dest(d1_data[1]), .master_t_user(d1_data[2]),
    .slave_t_valid(s1_valid), .slave_t_ready(s1_ready), .slave_t_data(s1_data),
    .slave_t_strb(s1_strb), .slave_t_keep(s1_keep), .slave_t_last(s1_last),
    .slave_t_id(s1_id), .slave_t_dest(s1_dest), .slave_t_user(s1_user)
  );

  initial forever #5 aclk = ~aclk;
  initial forever begin @(posedge aclk); cyc++; end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Push the first cnt beats of an n-beat packet starting at data 'base'.
  task automatic push_exp(input int which, input int base, input int n, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      if (which == 0) exp_q.push_back(pay(DW'(base + i), (i == n - 1)));
      else            exp1_q.push_back(pay(DW'(base + i), (i == n - 1)));
    end
  endtask

  // AXI-stream source: holds each beat until it is accepted.
  task automatic send(input int which, input int port, input int n, input int base, input int dly);
    logic acc;
    int   guard;
    repeat (dly) begin @(posedge aclk); #1; end
    for (int i = 0; i < n; i++) begin
      if (abort) break;
      if (which == 0) begin
        drv_valid[port] = 1'b1; drv_data[port] = DW'(base + i); drv_last[port] = (i == n - 1);
      end else begin
        d1_valid = 1'b1; d1_data = DW'(base + i); d1_last = (i == n - 1);
      end
      acc = 1'b0; guard = 0;
      while (!acc && !abort) begin
        @(negedge aclk);
        acc = (which == 0) ? m_ready[port] : d1_ready;
        @(posedge aclk); #1;
        if (acc && which == 0) begin
          acc_cnt[port]++;
          if (i == 0)     first_acc[port] = cyc - 1;
          if (i == n - 1) last_acc[port]  = cyc - 1;
        end
        guard++;
        if (guard > 200 && !acc) begin
          n_tests++; n_fail++;
          $display("FAIL accept_timeout: port %0d beat %0d never accepted", port, i);
          break;
        end
      end
      if (!acc) break;
    end
    if (which == 0) begin drv_valid[port] = 1'b0; drv_last[port] = 1'b0; end
    else begin d1_valid = 1'b0; d1_last = 1'b0; end
  endtask

  task automatic wait_empty(input string name);
    int g;
    g = 0;
    while ((exp_q.size() != 0 || exp1_q.size() != 0) && g < 300) begin
      @(posedge aclk); g++;
    end
    chk({name, "_drain"}, 128'(exp_q.size() + exp1_q.size()), 128'(0));
    repeat (2) @(posedge aclk);
    #1;
  endtask

  task automatic chk_times(input string name, input int which, input int c0, input int n, input offs_t offs);
    int got;
    got = (which == 0) ? out_cyc.size() : out_cyc1.size();
    chk({name, "_count"}, 128'(got), 128'(n));
    for (int i = 0; i < n && i < got; i++) begin
      if (which == 0) chk({name, "_cycle"}, 128'(out_cyc[i] - c0), 128'(offs[i]));
      else            chk({name, "_cycle"}, 128'(out_cyc1[i] - c0), 128'(offs[i]));
    end
  endtask

  // Output monitor: scoreboard, stall stability, ready-vs-occupancy rule.
  logic          stab_pend = 1'b0;
  logic [PW-1:0] prev_pay  = '0;
  initial forever begin
    @(negedge aclk);
    if (aresetn) begin
      if (stab_pend) begin
        chk("hold_valid", 128'(s_valid), 128'(1));
        chk("hold_payload", 128'(s_pay), 128'(prev_pay));
      end
      if (s_valid && s_ready) begin
        out_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL extra_beat: got %0h expected none", s_pay);
        end else begin
          chk("beat", 128'(s_pay), 128'(exp_q.pop_front()));
        end
      end
      stab_pend = s_valid && !s_ready;
      prev_pay  = s_pay;
      if (chk_occ && m_valid[6] && p6_in > 0)
        chk("ready_vs_skid", 128'(m_ready[6]), 128'(occ < 2));
      occ   = occ + int'(|(m_valid & m_ready)) - int'(s_valid & s_ready);
      p6_in = p6_in + int'(m_valid[6] & m_ready[6]);
      if (s1_valid && s1_ready) begin
        out_cyc1.push_back(cyc);
        if (exp1_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL extra_beat1: got %0h expected none", s1_pay);
        end else begin
          chk("beat1", 128'(s1_pay), 128'(exp1_q.pop_front()));
        end
      end
    end else begin
      stab_pend = 1'b0;
    end
  end

  logic [5:0] pat = 6'b011001;  // slave ready sequence 1,0,0,1,1,0 (bit 0 first)
  int c0;

  initial begin
    for (int p = 0; p < NP; p++) begin
      drv_valid[p] = 1'b0; drv_data[p] = '0; drv_last[p] = 1'b0;
      acc_cnt[p] = 0; first_acc[p] = -1; last_acc[p] = -1;
    end
    #2;
    chk("rst_s_valid", 128'(s_valid), 128'(0));
    chk("rst_m_ready", 128'(m_ready), 128'(0));
    chk("rst_s_payload", 128'(s_pay), 128'(0));
    chk("rst_s1_valid", 128'(s1_valid), 128'(0));
    repeat (2) @(posedge aclk);
    @(negedge aclk); aresetn = 1'b1;
    @(posedge aclk); #1;

    // Ports 0,3,5 each with a 2-beat packet from reset: order 0,3,5.
    push_exp(0, 'h10, 2, 2); push_exp(0, 'h20, 2, 2); push_exp(0, 'h28, 2, 2);
    out_cyc.delete(); c0 = cyc;
    fork
      send(0, 0, 2, 'h10, 0);
      send(0, 3, 2, 'h20, 0);
      send(0, 5, 2, 'h28, 0);
    join
    wait_empty("rr3");
    chk_times("rr3", 0, c0, 6, '{2, 3, 5, 6, 8, 9, 0, 0});

    // Ports 3 and 0 re-request after 5 won last: port 0 wins first.
    push_exp(0, 'h18, 2, 2); push_exp(0, 'h24, 2, 2);
    out_cyc.delete(); c0 = cyc;
    fork
      send(0, 3, 2, 'h24, 0);
      send(0, 0, 2, 'h18, 0);
    join
    wait_empty("rr_wrap");
    chk_times("rr_wrap", 0, c0, 4, '{2, 3, 5, 6, 0, 0, 0, 0});

    // Single 3-beat packet on port 2, data A0..A2.
    push_exp(0, 'hA0, 3, 3);
    out_cyc.delete(); c0 = cyc;
    send(0, 2, 3, 'hA0, 0);
    wait_empty("single");
    chk_times("single", 0, c0, 3, '{2, 3, 4, 0, 0, 0, 0, 0});

    // Port 1 streams 4 beats; port 4 requests one cycle later and waits.
    push_exp(0, 'h30, 4, 4); push_exp(0, 'h40, 2, 2);
    out_cyc.delete(); c0 = cyc;
    fork
      send(0, 1, 4, 'h30, 0);
      send(0, 4, 2, 'h40, 1);
    join
    wait_empty("hold");
    chk("hold_p1_last_acc", 128'(last_acc[1] - c0), 128'(4));
    chk("hold_p4_first_acc", 128'(first_acc[4] - c0), 128'(6));

    // 8-beat packet on port 6 with toggling slave ready.
    push_exp(0, 'h80, 8, 8);
    chk_occ = 1'b1;
    fork
      send(0, 6, 8, 'h80, 0);
      begin
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) begin
          s_ready = pat[k % 6];
          @(posedge aclk); #1;
        end
        s_ready = 1'b1;
      end
    join
    chk_occ = 1'b0;
    wait_empty("stall");

    // Reset during beat 2 of a 5-beat packet on port 2.
    push_exp(0, 'h50, 5, 2);
    fork
      send(0, 2, 5, 'h50, 0);
      begin
        for (int g = 0; g < 50 && acc_cnt[2] < 5; g++) begin
          if (acc_cnt[2] >= 2 + 3) break;
          @(negedge aclk);
          if (acc_cnt[2] >= 5) break;
          if (acc_cnt[2] - 3 >= 2) break;
        end
        #2;
        aresetn = 1'b0;
        #1;
        chk("midrst_s_valid", 128'(s_valid), 128'(0));
        chk("midrst_m_ready", 128'(m_ready), 128'(0));
        abort = 1'b1;
        occ = 0;
      end
    join
    repeat (3) @(posedge aclk);
    abort = 1'b0;
    @(negedge aclk); aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("midrst_drained", 128'(exp_q.size()), 128'(0));
    push_exp(0, 'h60, 2, 2); push_exp(0, 'h70, 2, 2);
    fork
      send(0, 7, 2, 'h70, 0);
      send(0, 0, 2, 'h60, 0);
    join
    wait_empty("post_rst");

    // N_PORT=1: back-to-back single-beat packets, one beat every 2 cycles.
    push_exp(1, 'h90, 1, 1); push_exp(1, 'h91, 1, 1);
    push_exp(1, 'h92, 1, 1); push_exp(1, 'h93, 1, 1);
    out_cyc1.delete(); c0 = cyc;
    for (int k = 0; k < 4; k++) send(1, 0, 1, 'h90 + k, 0);
    wait_empty("one_port");
    chk_times("one_port", 1, c0, 4, '{2, 4, 6, 8, 0, 0, 0, 0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
